// File: rtl/sm83_adr_seq.sv
// sm83_adr_seq: SM83 address latch with manual legacy path and an autonomous burst sequencer.
module sm83_adr_seq #(
  parameter int ADR_WIDTH  = 16,
  parameter int CNT_WIDTH  = 8,
  parameter int STEP_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADR_WIDTH-1:0]  ain,
  output logic [ADR_WIDTH-1:0]  aout,
  output logic [ADR_WIDTH-1:0]  apin,
  input  logic                  ctl_al_we,
  input  logic                  ctl_al_hi_ff,
  input  logic                  ctl_inc_oe,
  input  logic                  ctl_inc_dec,
  input  logic                  ctl_inc_cy,
  input  logic                  bst_start,
  input  logic [CNT_WIDTH-1:0]  bst_len,
  input  logic [STEP_WIDTH-1:0] bst_step,
  input  logic                  bst_dec,
  input  logic                  bst_wrap_en,
  input  logic [ADR_WIDTH-1:0]  bst_wrap_mask,
  input  logic                  bst_adv,
  output logic                  bst_busy,
  output logic                  bst_done,
  output logic [CNT_WIDTH-1:0]  bst_cnt
);
  localparam int HW = ADR_WIDTH / 2;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t r_state, w_nxt_state;
  logic [ADR_WIDTH-1:0]  r_al, r_mask;
  logic [CNT_WIDTH-1:0]  r_cnt;
  logic [STEP_WIDTH-1:0] r_step;
  logic                  r_dec, r_wrap_en;
  logic [ADR_WIDTH-1:0]  w_inc, w_man, w_stride, w_raw, w_nxt;
  assign w_inc    = ctl_inc_dec ? r_al - ADR_WIDTH'(ctl_inc_cy) : r_al + ADR_WIDTH'(ctl_inc_cy);
  assign w_man    = {ctl_inc_oe ? w_inc[ADR_WIDTH-1:HW] : ctl_al_hi_ff ? {(ADR_WIDTH-HW){1'b1}} : ain[ADR_WIDTH-1:HW],
                     ctl_inc_oe ? w_inc[HW-1:0] : ain[HW-1:0]};
  assign w_stride = ADR_WIDTH'(r_step);
  assign w_raw    = r_dec ? r_al - w_stride : r_al + w_stride;
  // The window mask applies to the full sum, so any carry out of the window is dropped.
  assign w_nxt    = r_wrap_en ? (r_al & ~r_mask) | (w_raw & r_mask) : w_raw;
  always_ff @(negedge clk)
    r_state <= reset ? IDLE : w_nxt_state;
  always_comb begin
    w_nxt_state = r_state;
    case (r_state)
      IDLE:    w_nxt_state = bst_start ? ((bst_len != '0) ? RUN : DONE) : IDLE;
      RUN:     w_nxt_state = (bst_adv && r_cnt == CNT_WIDTH'(1)) ? DONE : RUN;
      DONE:    w_nxt_state = IDLE;
      default: w_nxt_state = IDLE;
    endcase
  end
  always_comb begin
    apin     = (r_state == IDLE && ctl_al_we) ? w_man : r_al;
    bst_busy = r_state == RUN;
    bst_done = r_state == DONE;
    aout     = r_al;
    bst_cnt  = r_cnt;
  end
  always_ff @(negedge clk) begin
    if (reset) begin
      r_al      <= '0;
      r_cnt     <= '0;
      r_step    <= '0;
      r_dec     <= 1'b0;
      r_wrap_en <= 1'b0;
      r_mask    <= '0;
    end else begin
      case (r_state)
        IDLE:
          if (bst_start) begin
            r_al      <= ain;
            r_cnt     <= bst_len;
            r_step    <= bst_step;
            r_dec     <= bst_dec;
            r_wrap_en <= bst_wrap_en;
            r_mask    <= bst_wrap_mask;
          end else if (ctl_al_we) begin
            r_al <= apin;
          end
        RUN:
          if (bst_adv) begin
            r_al  <= w_nxt;
            r_cnt <= r_cnt - CNT_WIDTH'(1);
          end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_sm83_adr_seq.sv
// tb_sm83_adr_seq: scoreboard bench; issued burst addresses and done addresses are checked by a monitor.
module tb_sm83_adr_seq;
  logic        clk = 1'b0, reset = 1'b1;
  logic [15:0] ain = '0, aout, apin, bst_wrap_mask = '0;
  logic        ctl_al_we = 0, ctl_al_hi_ff = 0, ctl_inc_oe = 0, ctl_inc_dec = 0, ctl_inc_cy = 0;
  logic        bst_start = 0, bst_dec = 0, bst_wrap_en = 0, bst_adv = 0, bst_busy, bst_done;
  logic [7:0]  bst_len = '0, bst_cnt;
  logic [3:0]  bst_step = '0;
  int          checks = 0, failures = 0;
  logic [15:0] q_adr[$], q_done[$];

  sm83_adr_seq #(.ADR_WIDTH(16), .CNT_WIDTH(8), .STEP_WIDTH(4)) dut (
    .clk(clk), .reset(reset), .ain(ain), .aout(aout), .apin(apin),
    .ctl_al_we(ctl_al_we), .ctl_al_hi_ff(ctl_al_hi_ff), .ctl_inc_oe(ctl_inc_oe),
    .ctl_inc_dec(ctl_inc_dec), .ctl_inc_cy(ctl_inc_cy), .bst_start(bst_start),
    .bst_len(bst_len), .bst_step(bst_step), .bst_dec(bst_dec), .bst_wrap_en(bst_wrap_en),
    .bst_wrap_mask(bst_wrap_mask), .bst_adv(bst_adv), .bst_busy(bst_busy),
    .bst_done(bst_done), .bst_cnt(bst_cnt));

  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask

  // Monitor: DUT state changes on the falling edge, so sample on the rising edge.
  always @(posedge clk) begin
    if (bst_busy && bst_adv) begin
      if (q_adr.size() == 0) chk("unexpected_addr", 32'(apin), 32'hDEAD_BEEF);
      else chk("burst_addr", 32'(apin), 32'(q_adr.pop_front()));
    end
    if (bst_done) begin
      if (q_done.size() == 0) chk("unexpected_done", 32'(aout), 32'hDEAD_BEEF);
      else chk("done_addr", 32'(aout), 32'(q_done.pop_front()));
    end
  end

  task automatic nxt;
    @(negedge clk); #1;
  endtask

  task automatic smp;
    @(posedge clk);
  endtask

  task automatic idle_in;
    {ctl_al_we, ctl_al_hi_ff, ctl_inc_oe, ctl_inc_dec, ctl_inc_cy} = '0;
    {bst_start, bst_dec, bst_wrap_en, bst_adv} = '0;
  endtask

  task automatic start(input logic [15:0] base, input logic [7:0] len, input logic [3:0] step,
                       input logic dec, input logic wen, input logic [15:0] mask, input logic adv);
    nxt; idle_in;
    ain = base; bst_len = len; bst_step = step; bst_dec = dec;
    bst_wrap_en = wen; bst_wrap_mask = mask; bst_start = 1; bst_adv = adv;
    nxt; bst_start = 0; ain = 16'h5555; bst_step = 4'hF; bst_dec = ~dec;
  endtask

  task automatic wait_done(input int maxc, input logic [15:0] fin);
    int n = 0;
    do begin smp; n++; end while (!bst_done && n < maxc);
    chk("done_seen", 32'(bst_done), 32'd1);
    chk("done_al", 32'(aout), 32'(fin));
    chk("done_cnt", 32'(bst_cnt), 32'd0);
    chk("done_busy", 32'(bst_busy), 32'd0);
  endtask

  initial begin
    repeat (2) smp;
    chk("rst_al", 32'(aout), 32'd0);
    chk("rst_apin", 32'(apin), 32'd0);
    chk("rst_cnt", 32'(bst_cnt), 32'd0);
    chk("rst_flags", 32'({bst_busy, bst_done}), 32'd0);
    nxt; reset = 0;
    // Manual legacy path
    ctl_al_we = 1; ain = 16'h00FF;
    smp; chk("man_load_apin", 32'(apin), 32'h00FF);
    nxt; ctl_inc_oe = 1; ctl_inc_cy = 1;
    smp; chk("man_inc_apin", 32'(apin), 32'h0100);
    nxt; ctl_inc_dec = 1;
    smp; chk("man_inc_al", 32'(aout), 32'h0100);
    chk("man_dec_apin", 32'(apin), 32'h00FF);
    nxt; idle_in; ctl_al_we = 1; ctl_al_hi_ff = 1; ain = 16'h1234;
    smp; chk("man_dec_al", 32'(aout), 32'h00FF);
    nxt; idle_in;
    smp; chk("man_hiff_al", 32'(aout), 32'hFF34);
    chk("man_idle_apin", 32'(apin), 32'hFF34);
    // Basic burst
    q_adr.push_back(16'hC000); q_adr.push_back(16'hC001);
    q_adr.push_back(16'hC002); q_adr.push_back(16'hC003); q_done.push_back(16'hC004);
    start(16'hC000, 8'd4, 4'd1, 0, 0, 16'h0000, 1);
    smp; chk("basic_busy", 32'(bst_busy), 32'd1);
    chk("basic_cnt", 32'(bst_cnt), 32'd4);
    wait_done(8, 16'hC004);
    smp; chk("done_one_cycle", 32'(bst_done), 32'd0);
    // Stall and decrement
    q_adr.push_back(16'h8000); q_adr.push_back(16'h7FFE);
    q_adr.push_back(16'h7FFC); q_done.push_back(16'h7FFA);
    start(16'h8000, 8'd3, 4'd2, 1, 0, 16'h0000, 0);
    bst_adv = 1;
    nxt; bst_adv = 0;
    smp; chk("stall1_apin", 32'(apin), 32'h7FFE);
    nxt; bst_adv = 1;
    nxt; bst_adv = 0;
    smp; chk("stall2_apin", 32'(apin), 32'h7FFC);
    chk("stall2_cnt", 32'(bst_cnt), 32'd1);
    nxt; bst_adv = 1;
    wait_done(4, 16'h7FFA);
    // Wrap window
    q_adr.push_back(16'hFE9E); q_adr.push_back(16'hFE9F);
    q_adr.push_back(16'hFEA0); q_done.push_back(16'hFEA1);
    start(16'hFE9E, 8'd3, 4'd1, 0, 1, 16'h00FF, 1);
    wait_done(8, 16'hFEA1);
    q_adr.push_back(16'hFEFF); q_adr.push_back(16'hFE00); q_done.push_back(16'hFE01);
    start(16'hFEFF, 8'd2, 4'd1, 0, 1, 16'h00FF, 1);
    wait_done(8, 16'hFE01);
    // Zero length: done in the cycle right after start
    q_done.push_back(16'h1234);
    start(16'h1234, 8'd0, 4'd1, 0, 0, 16'h0000, 1);
    smp; chk("len0_done", 32'(bst_done), 32'd1);
    chk("len0_busy", 32'(bst_busy), 32'd0);
    // Full-range wrap up and down
    q_adr.push_back(16'hFFFF); q_adr.push_back(16'h0000); q_done.push_back(16'h0001);
    start(16'hFFFF, 8'd2, 4'd1, 0, 0, 16'h0000, 1);
    wait_done(8, 16'h0001);
    q_adr.push_back(16'h0001); q_adr.push_back(16'hFFFF); q_done.push_back(16'hFFFD);
    start(16'h0001, 8'd2, 4'd2, 1, 0, 16'h0000, 1);
    wait_done(8, 16'hFFFD);
    // Step zero
    repeat (3) q_adr.push_back(16'h5A5A);
    q_done.push_back(16'h5A5A);
    start(16'h5A5A, 8'd3, 4'd0, 0, 0, 16'h0000, 1);
    wait_done(8, 16'h5A5A);
    // Reset mid-burst, with an ignored manual write during RUN
    q_adr.push_back(16'h4000); q_adr.push_back(16'h4001);
    start(16'h4000, 8'd4, 4'd1, 0, 0, 16'h0000, 1);
    ctl_al_we = 1; ctl_inc_oe = 1; ctl_inc_cy = 1; ain = 16'hABCD;
    nxt; idle_in; bst_adv = 1;
    smp; chk("run_we_ignored", 32'(aout), 32'h4001);
    nxt; bst_adv = 0; reset = 1;
    smp; chk("pre_rst_cnt", 32'(bst_cnt), 32'd2);
    nxt; reset = 0;
    smp; chk("midrst_al", 32'(aout), 32'd0);
    chk("midrst_cnt", 32'(bst_cnt), 32'd0);
    chk("midrst_flags", 32'({bst_busy, bst_done}), 32'd0);
    repeat (4) smp;
    chk("addr_q_empty", 32'(q_adr.size()), 32'd0);
    chk("done_q_empty", 32'(q_done.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end
endmodule
